// File: rtl/inst_fetch_bridge.sv
// -----------------------------------------------------------------------------
// inst_fetch_bridge
//
// Instruction-side bridge between the core's ROM-style fetch port and a
// variable-latency req/ack read bus. It keeps a two-entry fetch buffer:
//   E0 - demand entry, filled by a DEMAND transaction on a buffer miss
//   E1 - prefetch entry, filled by a PREF transaction for E0.tag+1
// When the fetch address hits neither entry, stallreq_o is raised so the
// pipeline front end holds until the missing word has been filled.
//
// Ports
//   clk         in   1  clock, rising edge
//   rst         in   1  asynchronous reset, active low
//   rom_ce_i    in   1  fetch enable from the core
//   rom_addr_i  in  32  fetch address (bits [1:0] ignored)
//   rom_data_o  out 32  fetched instruction word (0 when disabled or missing)
//   stallreq_o  out  1  stall request: fetch enabled but buffer miss
//   flush_i     in   1  invalidate both entries, drop any in-flight fill
//   bus_req_o   out  1  bus read request (high in DEMAND and PREF)
//   bus_addr_o  out 32  bus word address, held for the whole transaction
//   bus_ack_i   in   1  read data valid, ends the transaction
//   bus_data_i  in  32  read data, sampled with bus_ack_i
// -----------------------------------------------------------------------------
module inst_fetch_bridge (
   input  logic        clk,
   input  logic        rst,
   input  logic        rom_ce_i,
   input  logic [31:0] rom_addr_i,
   output logic [31:0] rom_data_o,
   output logic        stallreq_o,
   input  logic        flush_i,
   output logic        bus_req_o,
   output logic [31:0] bus_addr_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_data_i
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DEMAND = 2'd1;
   localparam logic [1:0] ST_PREF   = 2'd2;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [1:0]  state_q,    state_d;
   logic        e0_valid_q, e0_valid_d;
   logic [29:0] e0_tag_q,   e0_tag_d;
   logic [31:0] e0_data_q,  e0_data_d;
   logic        e1_valid_q, e1_valid_d;
   logic [29:0] e1_tag_q,   e1_tag_d;
   logic [31:0] e1_data_q,  e1_data_d;
   logic [29:0] baddr_q,    baddr_d;    // word address of current/last request
   logic        discard_q,  discard_d;  // in-flight data must be dropped

   // ------------------------------------------------------------------------
   // Lookup
   // ------------------------------------------------------------------------
   logic [29:0] fetch_tag;
   logic        hit0;
   logic        hit1;
   logic        miss;
   logic [29:0] e0_next_tag;
   logic        e1_holds_next;
   logic        pref_go;
   logic        promote;
   logic        busy;
   logic        fill_ok;
   logic        addr_lsb_unused;

   assign fetch_tag       = rom_addr_i[31:2];
   assign addr_lsb_unused = ^rom_addr_i[1:0];

   assign hit0 = e0_valid_q & (e0_tag_q == fetch_tag);
   assign hit1 = e1_valid_q & (e1_tag_q == fetch_tag);
   assign miss = rom_ce_i & ~hit0 & ~hit1;

   // Sequential successor of E0; 30-bit arithmetic wraps the top word to 0.
   assign e0_next_tag   = e0_tag_q + 30'd1;
   assign e1_holds_next = e1_valid_q & (e1_tag_q == e0_next_tag);

   // Evaluated on the current E0: in a promoting cycle hit0 is 0, so the
   // prefetch for the promoted word is only decided the following cycle.
   assign pref_go = rom_ce_i & hit0 & ~e1_holds_next;
   assign promote = hit1 & ~hit0;

   assign busy    = (state_q != ST_IDLE);
   // A completing transaction may write its entry only if no flush has hit
   // it, either earlier in flight (discard_q) or on this very edge.
   assign fill_ok = busy & bus_ack_i & ~discard_q & ~flush_i;

   // ------------------------------------------------------------------------
   // Core-side outputs
   // ------------------------------------------------------------------------
   always_comb begin
      rom_data_o = 32'd0;
      if (rom_ce_i) begin
         if (hit0) begin
            rom_data_o = e0_data_q;
         end else if (hit1) begin
            rom_data_o = e1_data_q;
         end
      end
   end

   assign stallreq_o = miss;

   // ------------------------------------------------------------------------
   // Bus-side outputs (both straight from registers)
   // ------------------------------------------------------------------------
   assign bus_req_o  = busy;
   assign bus_addr_o = {baddr_q, 2'b00};

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      e0_valid_d = e0_valid_q;
      e0_tag_d   = e0_tag_q;
      e0_data_d  = e0_data_q;
      e1_valid_d = e1_valid_q;
      e1_tag_d   = e1_tag_q;
      e1_data_d  = e1_data_q;
      baddr_d    = baddr_q;
      discard_d  = discard_q;

      // Promotion moves E1 into E0. A demand fill landing on the same edge
      // owns E0, so the promotion is skipped and E1 is kept for next time.
      if (promote && !(state_q == ST_DEMAND && fill_ok)) begin
         e0_valid_d = 1'b1;
         e0_tag_d   = e1_tag_q;
         e0_data_d  = e1_data_q;
         e1_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (miss) begin
               state_d = ST_DEMAND;
               baddr_d = fetch_tag;
            end else if (pref_go) begin
               state_d = ST_PREF;
               baddr_d = e0_next_tag;
            end
         end

         ST_DEMAND: begin
            if (bus_ack_i) begin
               state_d   = ST_IDLE;
               discard_d = 1'b0;
               if (fill_ok) begin
                  e0_valid_d = 1'b1;
                  e0_tag_d   = baddr_q;
                  e0_data_d  = bus_data_i;
               end
            end else if (flush_i) begin
               discard_d = 1'b1;
            end
         end

         ST_PREF: begin
            // A miss here never starts a request; it is served by the fill
            // (same address) or by a DEMAND launched from the next IDLE cycle.
            if (bus_ack_i) begin
               state_d   = ST_IDLE;
               discard_d = 1'b0;
               if (fill_ok) begin
                  e1_valid_d = 1'b1;
                  e1_tag_d   = baddr_q;
                  e1_data_d  = bus_data_i;
               end
            end else if (flush_i) begin
               discard_d = 1'b1;
            end
         end

         default: begin
            state_d   = ST_IDLE;
            discard_d = 1'b0;
         end
      endcase

      // Flush wins over any fill or promotion on the same edge.
      if (flush_i) begin
         e0_valid_d = 1'b0;
         e1_valid_d = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         e0_valid_q <= 1'b0;
         e0_tag_q   <= 30'd0;
         e0_data_q  <= 32'd0;
         e1_valid_q <= 1'b0;
         e1_tag_q   <= 30'd0;
         e1_data_q  <= 32'd0;
         baddr_q    <= 30'd0;
         discard_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         e0_valid_q <= e0_valid_d;
         e0_tag_q   <= e0_tag_d;
         e0_data_q  <= e0_data_d;
         e1_valid_q <= e1_valid_d;
         e1_tag_q   <= e1_tag_d;
         e1_data_q  <= e1_data_d;
         baddr_q    <= baddr_d;
         discard_q  <= discard_d;
      end
   end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_bridge
//
// Self-checking bench for inst_fetch_bridge. A transaction-level reference
// model (two buffer entries plus one pending bus transaction record) predicts
// the outputs every cycle. A directed vector table, hand-written corner-case
// sequences and a randomized fetch stream are all checked against it.
// -----------------------------------------------------------------------------
module tb_inst_fetch_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        rom_ce_i;
   logic [31:0] rom_addr_i;
   logic [31:0] rom_data_o;
   logic        stallreq_o;
   logic        flush_i;
   logic        bus_req_o;
   logic [31:0] bus_addr_o;
   logic        bus_ack_i;
   logic [31:0] bus_data_i;

   always #5 clk = ~clk;

   inst_fetch_bridge dut (
      .clk        (clk),
      .rst        (rst),
      .rom_ce_i   (rom_ce_i),
      .rom_addr_i (rom_addr_i),
      .rom_data_o (rom_data_o),
      .stallreq_o (stallreq_o),
      .flush_i    (flush_i),
      .bus_req_o  (bus_req_o),
      .bus_addr_o (bus_addr_o),
      .bus_ack_i  (bus_ack_i),
      .bus_data_i (bus_data_i)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model: buffer entries, one pending transaction, slave latency
   // ------------------------------------------------------------------------
   bit          m_vld [2];
   logic [29:0] m_tag [2];
   logic [31:0] m_dat [2];
   bit          p_act, p_dem, p_disc;
   logic [29:0] p_addr;
   int          p_wait, p_lat;
   logic [29:0] m_baddr;
   int          lat_fix = 0;       // -1: random latency 0..3 per transaction

   // Last observed DUT outputs
   logic [31:0] a_data, a_baddr;
   logic        a_stall, a_req, prev_req;
   logic [31:0] req_log [$];

   function automatic logic [31:0] mem_word(input logic [29:0] w);
      logic [31:0] a;
      a = {w, 2'b00};
      return (a == 32'h0000_0100) ? 32'h3402_0020 : (a ^ 32'hA5A5_0000);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_vld[i] = 1'b0;
         m_tag[i] = '0;
         m_dat[i] = '0;
      end
      p_act = 0; p_dem = 0; p_disc = 0; p_addr = '0; p_wait = 0; p_lat = 0;
      m_baddr = '0;
      prev_req = 1'b0;
   endtask

   task automatic launch(input bit dem, input logic [29:0] w);
      p_act   = 1'b1;
      p_dem   = dem;
      p_addr  = w;
      p_wait  = 0;
      p_disc  = 1'b0;
      p_lat   = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
      m_baddr = w;
   endtask

   // One clock cycle: drive inputs, compare outputs, advance the model.
   task automatic step(input bit ce, input logic [31:0] addr, input bit fl);
      logic [29:0] t;
      bit          h0, h1, ack, dem_fill, pref_fill, go_dem, go_pref;
      logic [29:0] nxt;
      logic [31:0] e_data;
      @(negedge clk);
      rst        = 1'b1;
      rom_ce_i   = ce;
      rom_addr_i = addr;
      flush_i    = fl;
      ack        = p_act && (p_wait >= p_lat);
      bus_ack_i  = ack;
      bus_data_i = ack ? mem_word(p_addr) : $urandom;
      #1;
      t  = addr[31:2];
      h0 = m_vld[0] && (m_tag[0] == t);
      h1 = m_vld[1] && (m_tag[1] == t);
      e_data = !ce ? 32'd0 : h0 ? m_dat[0] : h1 ? m_dat[1] : 32'd0;
      a_data = rom_data_o; a_stall = stallreq_o; a_req = bus_req_o; a_baddr = bus_addr_o;
      check("data",  a_data,  e_data);
      check("stall", {31'd0, a_stall}, {31'd0, (ce && !h0 && !h1)});
      check("req",   {31'd0, a_req},   {31'd0, p_act});
      check("baddr", a_baddr, {m_baddr, 2'b00});
      if (a_req && !prev_req) begin
         $display("bus request addr=%h", a_baddr);
         req_log.push_back(a_baddr);
      end
      prev_req = a_req;

      @(posedge clk);
      // Decisions from the pre-edge picture
      nxt       = m_tag[0] + 30'd1;
      go_dem    = !p_act && ce && !h0 && !h1;
      go_pref   = !p_act && !go_dem && ce && h0 && !(m_vld[1] && m_tag[1] == nxt);
      dem_fill  = p_act && ack && p_dem  && !p_disc && !fl;
      pref_fill = p_act && ack && !p_dem && !p_disc && !fl;
      if (h1 && !h0 && !dem_fill) begin
         m_vld[0] = 1'b1; m_tag[0] = m_tag[1]; m_dat[0] = m_dat[1]; m_vld[1] = 1'b0;
      end
      if (dem_fill) begin
         m_vld[0] = 1'b1; m_tag[0] = p_addr; m_dat[0] = mem_word(p_addr);
      end
      if (pref_fill) begin
         m_vld[1] = 1'b1; m_tag[1] = p_addr; m_dat[1] = mem_word(p_addr);
      end
      if (p_act) begin
         if (ack) begin
            p_act  = 1'b0;
            p_disc = 1'b0;
         end else begin
            p_wait++;
            if (fl) p_disc = 1'b1;
         end
      end else if (go_dem) begin
         launch(1'b1, t);
      end else if (go_pref) begin
         launch(1'b0, nxt);
      end
      if (fl) begin
         m_vld[0] = 1'b0;
         m_vld[1] = 1'b0;
      end
   endtask

   // Hold reset with random bus/address inputs (core disabled), check zeros.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; rom_ce_i = 1'b0; flush_i = 1'b0; bus_ack_i = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         rom_addr_i = $urandom; flush_i = 1'($urandom); bus_ack_i = 1'($urandom);
         bus_data_i = $urandom;
         #1;
         check("rst_data",  rom_data_o, 32'd0);
         check("rst_stall", {31'd0, stallreq_o}, 32'd0);
         check("rst_req",   {31'd0, bus_req_o},  32'd0);
         check("rst_baddr", bus_addr_o, 32'd0);
      end
      flush_i = 1'b0; bus_ack_i = 1'b0;
   endtask

   typedef struct packed {
      logic        ce;
      logic [31:0] addr;
      logic        fl;
      logic        e_stall;
      logic        e_req;
      logic [31:0] e_baddr;
      logic [31:0] e_data;
   } vec_t;

   vec_t tbl [10];

   initial begin
      logic [31:0] pc;
      int          dups;
      bit          found;

      rst = 1'b0; rom_ce_i = 1'b0; rom_addr_i = '0; flush_i = 1'b0;
      bus_ack_i = 1'b0; bus_data_i = '0;
      model_reset();

      // Zero-wait slave: demand 0x100, prefetch 0x104, promotion, miss on
      // an in-flight prefetch target, then core disabled.
      tbl[0] = '{1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h000, 32'h0};
      tbl[1] = '{1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0};
      tbl[2] = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h100, 32'h3402_0020};
      tbl[3] = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 32'h104, 32'h3402_0020};
      tbl[4] = '{1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 32'h104, 32'hA5A5_0104};
      tbl[5] = '{1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 32'h104, 32'hA5A5_0104};
      tbl[6] = '{1'b1, 32'h108, 1'b0, 1'b1, 1'b1, 32'h108, 32'h0};
      tbl[7] = '{1'b1, 32'h108, 1'b0, 1'b0, 1'b0, 32'h108, 32'hA5A5_0108};
      tbl[8] = '{1'b0, 32'h108, 1'b0, 1'b0, 1'b0, 32'h108, 32'h0};
      tbl[9] = '{1'b0, 32'h200, 1'b0, 1'b0, 1'b0, 32'h108, 32'h0};

      // --- Reset and release with core fetching 0x0 ---
      do_reset();
      lat_fix = 1;
      step(1'b1, 32'h0, 1'b0);
      check("rel_stall", {31'd0, a_stall}, 32'd1);
      step(1'b1, 32'h0, 1'b0);
      check("rel_req",   {31'd0, a_req}, 32'd1);
      check("rel_baddr", a_baddr, 32'h0);

      // --- Directed vector table ---
      do_reset();
      lat_fix = 0;
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].ce, tbl[i].addr, tbl[i].fl);
         check($sformatf("tbl%0d_stall", i), {31'd0, a_stall}, {31'd0, tbl[i].e_stall});
         check($sformatf("tbl%0d_req", i),   {31'd0, a_req},   {31'd0, tbl[i].e_req});
         check($sformatf("tbl%0d_baddr", i), a_baddr, tbl[i].e_baddr);
         check($sformatf("tbl%0d_data", i),  a_data,  tbl[i].e_data);
      end

      // --- Sequential run 0x0 -> 0x4 -> 0x8, 3-wait slave ---
      do_reset();
      lat_fix = 3;
      req_log.delete();
      pc = 32'h0;
      for (int i = 0; i < 30; i++) begin
         step(1'b1, pc, 1'b0);
         if (!a_stall && pc < 32'h8) pc = pc + 32'h4;
      end
      dups = 0;
      for (int i = 0; i < req_log.size(); i++)
         for (int j = i + 1; j < req_log.size(); j++)
            if (req_log[i] == req_log[j]) dups++;
      check("seq_dup_req",   dups, 0);
      check("seq_req_count", req_log.size(), 4);
      check("seq_last_data", a_data, 32'hA5A5_0008);

      // --- Miss during PREF to a different target ---
      do_reset();
      lat_fix = 3;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1'b1, 32'h100, 1'b0);
         if (a_req && a_baddr == 32'h104) found = 1;
      end
      check("pref104_seen", {31'd0, found}, 32'd1);
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         step(1'b1, 32'h200, 1'b0);
         if (!a_req) found = 1;
         else check("pref_hold_addr", a_baddr, 32'h104);
      end
      check("pref_ack_seen", {31'd0, found}, 32'd1);
      step(1'b1, 32'h104, 1'b0);          // DEMAND 0x200 out, E1 still 0x104
      check("dem200_req",   {31'd0, a_req}, 32'd1);
      check("dem200_addr",  a_baddr, 32'h200);
      check("e1_kept_104",  a_data, 32'hA5A5_0104);

      // --- Flush mid-DEMAND ---
      do_reset();
      lat_fix = 3;
      step(1'b1, 32'h40, 1'b0);
      step(1'b1, 32'h40, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 32'h40, 1'b0);
      check("flush_remiss_stall", {31'd0, a_stall}, 32'd1);
      step(1'b1, 32'h40, 1'b0);
      check("flush_idle_gap", {31'd0, a_req}, 32'd0);
      check("flush_idle_stall", {31'd0, a_stall}, 32'd1);
      step(1'b1, 32'h40, 1'b0);
      check("flush_redemand_req",  {31'd0, a_req}, 32'd1);
      check("flush_redemand_addr", a_baddr, 32'h40);

      // --- Address wrap and disabled port ---
      do_reset();
      lat_fix = 0;
      step(1'b1, 32'hFFFF_FFFC, 1'b0);
      step(1'b1, 32'hFFFF_FFFC, 1'b0);
      step(1'b1, 32'hFFFF_FFFC, 1'b0);
      check("wrap_hit", a_data, 32'h5A5A_FFFC);
      step(1'b1, 32'hFFFF_FFFC, 1'b0);
      check("wrap_req",   {31'd0, a_req}, 32'd1);
      check("wrap_baddr", a_baddr, 32'h0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, (i == 0) ? 32'hFFFF_FFFC : $urandom, 1'b0);
         check("dis_data", a_data, 32'd0);
         check("dis_req",  {31'd0, a_req}, 32'd0);
      end

      // --- Asynchronous reset in the middle of a transaction ---
      do_reset();
      lat_fix = 3;
      step(1'b1, 32'h300, 1'b0);
      step(1'b1, 32'h300, 1'b0);
      check("mid_req_before", {31'd0, a_req}, 32'd1);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_req",   {31'd0, bus_req_o}, 32'd0);
      check("mid_rst_baddr", bus_addr_o, 32'd0);
      model_reset();

      // --- Randomized fetch stream ---
      do_reset();
      lat_fix = -1;
      pc = 32'h1000;
      for (int i = 0; i < 3000; i++) begin
         int r;
         step(($urandom % 8) != 0, pc | ($urandom % 4), ($urandom % 32) == 0);
         r = int'($urandom % 100);
         if (!a_stall) begin
            if (r < 70)      pc = pc + 32'h4;
            else if (r < 90) pc = 32'h1000 + 4 * $urandom_range(0, 15);
            else if (r < 93) pc = 32'hFFFF_FFF8;
         end
         pc = {pc[31:2], 2'b00};
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
